// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
//
// Sequences one data-memory access per M-stage load/store over a
// req/gnt/rvalid handshake. The pipeline is held while the access is in
// flight, and loads return sign- or zero-extended data.
//
// State  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no access in flight; an access in M is latched and stalls
// REQ    | dmem_req high, request fields frozen until dmem_gnt
// RESP   | load granted, waiting for dmem_rvalid
// DONE   | stall released for one cycle, result/status pulses valid
//
// Parameters
//   XLEN            data/address width (RV32I: 32)
//   TIMEOUT_CYCLES  cycles allowed in REQ+RESP before bus_err, 0 = no watchdog
//
// Optional feature: define DMEM_MISALIGN_TRAP_EN to trap misaligned
// half/word accesses (no bus request, misalign_m pulse). Without it the low
// address bits are force-aligned and misalign_m is tied low.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   mem_read_m, mem_write_m         M-stage load / store (store wins)
//   funct3_m, addr_m, wdata_m       access size/sign, byte address, rs2
//   stall_m                         pipeline hold, combinational
//   dmem_req/we/addr/be/wdata       request to data memory (registered)
//   dmem_gnt, dmem_rvalid, dmem_rdata  memory handshake and read data
//   load_data_m, load_valid         extended load result and its pulse
//   bus_err                         watchdog expiry pulse
//   misalign_m                      misaligned access pulse

module dmem_access_ctrl #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_read_m,
    input  logic            mem_write_m,
    input  logic [2:0]      funct3_m,
    input  logic [XLEN-1:0] addr_m,
    input  logic [XLEN-1:0] wdata_m,
    output logic            stall_m,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] load_data_m,
    output logic            load_valid,
    output logic            bus_err,
    output logic            misalign_m
);

    localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic            access;
    logic            misaligned;
    logic [1:0]      off_eff;
    logic [3:0]      be_calc;
    logic [XLEN-1:0] wdata_calc;

    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic [WD_W-1:0] wd_cnt;
    logic            wd_expired;

    logic            start_acc;
    logic            trap;
    logic            capture;
    logic            timeout;

    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] ext_data;

    assign access = mem_read_m | mem_write_m;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misaligned = ((funct3_m[1:0] == 2'b01) && addr_m[0]) ||
                        (funct3_m[1] && (addr_m[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Lane offset after forced alignment; for aligned accesses it is just
    // addr[1:0], so the trap build can share it.
    always_comb begin
        off_eff    = addr_m[1:0];
        be_calc    = 4'b1111;
        wdata_calc = wdata_m;
        case (funct3_m[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << off_eff;
                wdata_calc = {4{wdata_m[7:0]}};
            end
            2'b01: begin
                off_eff    = {addr_m[1], 1'b0};
                be_calc    = 4'b0011 << off_eff;
                wdata_calc = {2{wdata_m[15:0]}};
            end
            default: begin
                off_eff    = 2'b00;
            end
        endcase
    end

    always_comb begin
        byte_sel = dmem_rdata[{off_q, 3'b000} +: 8];
        half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3_q[1:0])
            2'b00:   ext_data = {{(XLEN-8){byte_sel[7] & ~f3_q[2]}}, byte_sel};
            2'b01:   ext_data = {{(XLEN-16){half_sel[15] & ~f3_q[2]}}, half_sel};
            default: ext_data = dmem_rdata;
        endcase
    end

    assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_cnt >= WD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A handshake completing in the last watchdog cycle wins over expiry.
    always_comb begin
        state_d   = state_q;
        stall_m   = 1'b0;
        start_acc = 1'b0;
        trap      = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    stall_m = 1'b1;
                    if (misaligned) begin
                        trap    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        start_acc = 1'b1;
                        state_d   = S_REQ;
                    end
                end
            end
            S_REQ: begin
                stall_m = 1'b1;
                if (dmem_gnt) begin
                    state_d = dmem_we ? S_DONE : S_RESP;
                end else if (wd_expired) begin
                    timeout = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_RESP: begin
                stall_m = 1'b1;
                if (dmem_rvalid) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end else if (wd_expired) begin
                    timeout = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (!rst_n) begin
            stall_m = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_be     <= 4'b0000;
            dmem_wdata  <= '0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            wd_cnt      <= '0;
            load_data_m <= '0;
            load_valid  <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            bus_err    <= 1'b0;

            if (start_acc) begin
                dmem_req   <= 1'b1;
                dmem_we    <= mem_write_m;
                dmem_addr  <= {addr_m[XLEN-1:2], 2'b00};
                dmem_be    <= be_calc;
                dmem_wdata <= wdata_calc;
                f3_q       <= funct3_m;
                off_q      <= off_eff;
                wd_cnt     <= '0;
            end else if ((state_q == S_REQ || state_q == S_RESP) && (wd_cnt != '1)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end

            if (state_q == S_REQ && state_d != S_REQ) begin
                dmem_req <= 1'b0;
            end

            if (capture) begin
                load_data_m <= ext_data;
                load_valid  <= 1'b1;
            end

            if (timeout) begin
                load_data_m <= '0;
                bus_err     <= 1'b1;
            end

            if (trap) begin
                load_data_m <= '0;
            end
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_m <= 1'b0;
        end else begin
            misalign_m <= trap;
        end
    end
`else
    assign misalign_m = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read_m;
    logic        mem_write_m;
    logic [2:0]  funct3_m;
    logic [31:0] addr_m;
    logic [31:0] wdata_m;
    logic        stall_m;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] load_data_m;
    logic        load_valid;
    logic        bus_err;
    logic        misalign_m;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read_m  (mem_read_m),
        .mem_write_m (mem_write_m),
        .funct3_m    (funct3_m),
        .addr_m      (addr_m),
        .wdata_m     (wdata_m),
        .stall_m     (stall_m),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .load_data_m (load_data_m),
        .load_valid  (load_valid),
        .bus_err     (bus_err),
        .misalign_m  (misalign_m)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access: the bench plays the memory (gnt after gd request
    // cycles, rvalid rdly cycles after gnt) and checks against a model built
    // from access size, alignment and the REQ+RESP cycle budget.
    task automatic run_access(input string tag, input logic we, input logic rd,
                              input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input int gd, input int rdly,
                              input logic [31:0] rdat);
        int          size;
        int          lo;
        int          ealo;
        logic        is_load;
        logic        mis;
        logic        trp;
        logic        tmo;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] v;
        logic [31:0] exp_ld;
        int          exp_stalls;
        int          exp_reqs;
        int          stalls;
        int          reqs;
        int          after;
        logic        done;

        size    = f3[1] ? 4 : (f3[0] ? 2 : 1);
        lo      = int'(a[1:0]);
        mis     = (lo % size) != 0;
        ealo    = lo - (lo % size);
        is_load = rd && !we;
        trp     = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        trp     = mis;
`endif
        exp_addr = a & 32'hFFFF_FFFC;
        exp_be   = 4'(((1 << size) - 1) << ealo);
        if (size == 1)      exp_wd = wd[7:0] * 32'h0101_0101;
        else if (size == 2) exp_wd = wd[15:0] * 32'h0001_0001;
        else                exp_wd = wd;

        v = rdat >> (8 * ealo);
        if (size == 1) begin
            exp_ld = v & 32'h0000_00FF;
            if (!f3[2] && exp_ld[7]) exp_ld = exp_ld | 32'hFFFF_FF00;
        end else if (size == 2) begin
            exp_ld = v & 32'h0000_FFFF;
            if (!f3[2] && exp_ld[15]) exp_ld = exp_ld | 32'hFFFF_0000;
        end else begin
            exp_ld = rdat;
        end

        tmo = !trp && (is_load ? (gd + 1 + rdly > TMO) : (gd + 1 > TMO));
        if (trp)          exp_stalls = 1;
        else if (tmo)     exp_stalls = 1 + TMO;
        else if (is_load) exp_stalls = 1 + gd + 1 + rdly;
        else              exp_stalls = 1 + gd + 1;
        exp_reqs = trp ? 0 : ((gd + 1 < TMO) ? gd + 1 : TMO);

        @(negedge clk);
        mem_read_m  = rd;
        mem_write_m = we;
        funct3_m    = f3;
        addr_m      = a;
        wdata_m     = wd;
        stalls = 0;
        reqs   = 0;
        after  = -1;
        done   = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c != 0) @(negedge clk);
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom;
            if (after >= 0) begin
                after++;
                if (is_load && after == rdly) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = rdat;
                end
            end
            if (dmem_req) begin
                check({tag, "_req_addr"}, dmem_addr, exp_addr);
                check({tag, "_req_be"}, 32'(dmem_be), 32'(exp_be));
                check({tag, "_req_we"}, 32'(dmem_we), 32'(we));
                if (we) check({tag, "_req_wdata"}, dmem_wdata, exp_wd);
                if (reqs == gd) begin
                    dmem_gnt = 1'b1;
                    after    = 0;
                end else if ($urandom_range(0, 1) == 1) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = ~rdat;
                end
                reqs++;
            end
            #1;
            if (stall_m) begin
                stalls++;
            end else begin
                done = 1'b1;
                check({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
                check({tag, "_reqs"}, 32'(reqs), 32'(exp_reqs));
                check({tag, "_load_valid"}, 32'(load_valid), 32'(is_load && !tmo && !trp));
                check({tag, "_bus_err"}, 32'(bus_err), 32'(tmo));
                check({tag, "_misalign"}, 32'(misalign_m), 32'(trp));
                check({tag, "_req_done"}, 32'(dmem_req), 32'd0);
                if (is_load) check({tag, "_load_data"}, load_data_m, (tmo || trp) ? 32'd0 : exp_ld);
            end
        end
        check({tag, "_completed"}, 32'(done), 32'd1);

        @(negedge clk);
        mem_read_m  = 1'b0;
        mem_write_m = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        #1;
        check({tag, "_pulse_lv"}, 32'(load_valid), 32'd0);
        check({tag, "_pulse_be"}, 32'(bus_err | misalign_m), 32'd0);
        check({tag, "_idle_stall"}, 32'(stall_m), 32'd0);
        if (!done) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic        r_we;
        logic        r_rd;
        logic [2:0]  r_f3;
        logic [31:0] r_a;

        rst_n       = 1'b0;
        mem_read_m  = 1'b1;
        mem_write_m = 1'b0;
        funct3_m    = 3'b010;
        addr_m      = 32'h100;
        wdata_m     = 32'h0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_stall", 32'(stall_m), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_we", 32'(dmem_we), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_be", 32'(dmem_be), 32'd0);
        check("rst_ld", load_data_m, 32'd0);
        check("rst_flags", {29'd0, load_valid, bus_err, misalign_m}, 32'd0);
        mem_read_m = 1'b0;
        rst_n      = 1'b1;

        run_access("sw",     1'b1, 1'b0, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 1, 32'h0);
        run_access("lb",     1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 0, 1, 32'h80FF_FF7F);
        run_access("lhu",    1'b0, 1'b1, 3'b101, 32'h102, 32'h0, 4, 1, 32'hBEEF_1234);
        run_access("lh",     1'b0, 1'b1, 3'b001, 32'h102, 32'h0, 1, 2, 32'hBEEF_1234);
        run_access("lbu",    1'b0, 1'b1, 3'b100, 32'h101, 32'h0, 0, 1, 32'h0000_9A00);
        run_access("sb",     1'b1, 1'b0, 3'b000, 32'h102, 32'h0000_00A5, 2, 1, 32'h0);
        run_access("sh",     1'b1, 1'b0, 3'b001, 32'h106, 32'h0000_C3D4, 0, 1, 32'h0);
        run_access("rw_both", 1'b1, 1'b1, 3'b010, 32'h204, 32'h1234_5678, 1, 1, 32'h0);
        run_access("tmo",    1'b0, 1'b1, 3'b010, 32'h200, 32'h0, 99, 1, 32'h5555_AAAA);
        run_access("tmo_st", 1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 99, 1, 32'h0);
        run_access("lw_mis", 1'b0, 1'b1, 3'b010, 32'h102, 32'h0, 0, 1, 32'hCAFE_F00D);
        run_access("lh_mis", 1'b0, 1'b1, 3'b001, 32'h103, 32'h0, 0, 1, 32'h8001_7F02);

        // reset while waiting in RESP, then a late rvalid
        @(negedge clk);
        mem_read_m = 1'b1;
        funct3_m   = 3'b010;
        addr_m     = 32'h300;
        @(negedge clk);
        #1;
        check("mid_req", 32'(dmem_req), 32'd1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        check("mid_resp_stall", 32'(stall_m), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_stall", 32'(stall_m), 32'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        mem_read_m  = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1234_5678;
        #1;
        check("mid_after_stall", 32'(stall_m), 32'd0);
        check("mid_after_req", 32'(dmem_req), 32'd0);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1;
        check("mid_late_lv", 32'(load_valid), 32'd0);
        check("mid_late_ld", load_data_m, 32'd0);
        @(negedge clk);
        #1;
        check("mid_late_lv2", 32'(load_valid), 32'd0);

        for (int i = 0; i < 40; i++) begin
            r_we = 1'($urandom_range(0, 1));
            r_rd = r_we ? 1'($urandom_range(0, 1)) : 1'b1;
            if (r_we) begin
                r_f3 = 3'($urandom_range(0, 2));
            end else begin
                case ($urandom_range(0, 4))
                    0:       r_f3 = 3'b000;
                    1:       r_f3 = 3'b001;
                    2:       r_f3 = 3'b010;
                    3:       r_f3 = 3'b100;
                    default: r_f3 = 3'b101;
                endcase
            end
            r_a = 32'h1000 + 32'($urandom_range(0, 255));
            run_access($sformatf("rnd%0d", i), r_we, r_rd, r_f3, r_a, $urandom,
                       $urandom_range(0, 5), $urandom_range(1, 4), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
